// File: rtl/vc_packetizer.sv
// rtl/vc_packetizer.sv - splits one wide message into NoC flits sent on a single VC
// under per-VC credit flow control.
module vc_packetizer #(
  parameter int N_ADDR_WIDTH    = 4,
  parameter int VC_ADDR_WIDTH   = 2,
  parameter int FLIT_DATA_WIDTH = 128,
  parameter int NUM_FLITS       = 4,
  parameter int BUFFER_DEPTH    = 8
) (
  input  logic                                                    clk,
  input  logic                                                    rst,
  input  logic [NUM_FLITS*FLIT_DATA_WIDTH-1:0]                    data_in,
  input  logic [N_ADDR_WIDTH-1:0]                                 dest_in,
  input  logic [VC_ADDR_WIDTH-1:0]                                vc_in,
  input  logic                                                    valid_in,
  output logic                                                    ready_out,
  output logic [3+VC_ADDR_WIDTH+N_ADDR_WIDTH+FLIT_DATA_WIDTH-1:0] flit_out,
  input  logic [(2**VC_ADDR_WIDTH)-1:0]                           credit_in
);

  localparam int NUM_VC = 2 ** VC_ADDR_WIDTH;
  localparam int FLIT_W = 3 + VC_ADDR_WIDTH + N_ADDR_WIDTH + FLIT_DATA_WIDTH;
  localparam int CRED_W = $clog2(BUFFER_DEPTH + 1);
  localparam int K_W    = (NUM_FLITS > 1) ? $clog2(NUM_FLITS) : 1;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t                                       state_q;
  logic [NUM_FLITS-1:0][FLIT_DATA_WIDTH-1:0]    data_q;
  logic [N_ADDR_WIDTH-1:0]                      dest_q;
  logic [VC_ADDR_WIDTH-1:0]                     vc_q;
  logic [K_W-1:0]                               k_q;
  logic [FLIT_W-1:0]                            flit_q;
  logic [CRED_W-1:0]                            credit_q [NUM_VC];
  logic [CRED_W-1:0]                            credit_d [NUM_VC];

  logic                                         accept;
  logic                                         can_send;
  logic                                         last_flit;
  logic [K_W-1:0]                               slice_idx;
  logic [FLIT_W-1:0]                            flit_d;

  assign ready_out = (state_q == IDLE) && !rst;
  assign accept    = valid_in && ready_out;
  assign flit_out  = flit_q;

  // The send decision only looks at the registered counter, so a credit
  // returned this cycle becomes spendable on the following one.
  assign can_send  = (state_q == SEND) && (credit_q[vc_q] != '0);
  assign last_flit = (k_q == K_W'(NUM_FLITS - 1));

  // Flit 0 carries the most-significant slice of the message.
  assign slice_idx = K_W'(NUM_FLITS - 1) - k_q;

  always_comb begin
    flit_d = {1'b1, (k_q == '0), last_flit, vc_q, dest_q, data_q[slice_idx]};
  end

  always_comb begin
    for (int v = 0; v < NUM_VC; v++) begin
      credit_d[v] = credit_q[v];
      if (can_send && (vc_q == VC_ADDR_WIDTH'(v))) begin
        if (!credit_in[v]) begin
          credit_d[v] = credit_q[v] - CRED_W'(1);
        end
      end else if (credit_in[v] && (credit_q[v] != CRED_W'(BUFFER_DEPTH))) begin
        credit_d[v] = credit_q[v] + CRED_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int v = 0; v < NUM_VC; v++) begin
        credit_q[v] <= CRED_W'(BUFFER_DEPTH);
      end
    end else begin
      for (int v = 0; v < NUM_VC; v++) begin
        credit_q[v] <= credit_d[v];
      end
    end
  end

  // Holding registers are only meaningful after an accept, so they carry no reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      data_q <= data_in;
      dest_q <= dest_in;
      vc_q   <= vc_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      k_q     <= '0;
      flit_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          flit_q <= '0;
          if (valid_in) begin
            k_q     <= '0;
            state_q <= SEND;
          end
        end
        SEND: begin
          if (can_send) begin
            flit_q <= flit_d;
            k_q    <= k_q + K_W'(1);
            if (last_flit) begin
              state_q <= IDLE;
            end
          end else begin
            flit_q <= '0;
          end
        end
        default: begin
          state_q <= IDLE;
          flit_q  <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vc_packetizer.sv
// tb/tb_vc_packetizer.sv - randomized and directed checks of vc_packetizer against a
// message-level reference model with integer credit counters.
module tb_vc_packetizer;

  localparam int NA  = 4;
  localparam int VA  = 2;
  localparam int FDW = 128;
  localparam int NF  = 4;
  localparam int BD  = 8;
  localparam int NVC = 4;
  localparam int MW  = NF * FDW;
  localparam int FW  = 3 + VA + NA + FDW;

  logic          clk = 1'b0;
  logic          rst;
  logic [MW-1:0] data_in;
  logic [NA-1:0] dest_in;
  logic [VA-1:0] vc_in;
  logic          valid_in;
  logic          ready_out;
  logic [FW-1:0] flit_out;
  logic [NVC-1:0] credit_in;

  logic [FDW-1:0] d1_data;
  logic [NA-1:0]  d1_dest;
  logic [VA-1:0]  d1_vc;
  logic           d1_valid;
  logic           d1_ready;
  logic [FW-1:0]  d1_flit;
  logic [NVC-1:0] d1_credit;

  always #5 clk = ~clk;

  vc_packetizer #(.N_ADDR_WIDTH(NA), .VC_ADDR_WIDTH(VA), .FLIT_DATA_WIDTH(FDW),
                  .NUM_FLITS(NF), .BUFFER_DEPTH(BD)) u_dut (
    .clk(clk), .rst(rst), .data_in(data_in), .dest_in(dest_in), .vc_in(vc_in),
    .valid_in(valid_in), .ready_out(ready_out), .flit_out(flit_out), .credit_in(credit_in));

  vc_packetizer #(.N_ADDR_WIDTH(NA), .VC_ADDR_WIDTH(VA), .FLIT_DATA_WIDTH(FDW),
                  .NUM_FLITS(1), .BUFFER_DEPTH(BD)) u_dut1 (
    .clk(clk), .rst(rst), .data_in(d1_data), .dest_in(d1_dest), .vc_in(d1_vc),
    .valid_in(d1_valid), .ready_out(d1_ready), .flit_out(d1_flit), .credit_in(d1_credit));

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  // reference model state
  bit            m_busy;
  bit            m_accept;
  int            m_k;
  logic [MW-1:0] m_msg;
  logic [NA-1:0] m_dest;
  logic [VA-1:0] m_vc;
  int            m_cred [NVC];
  logic [FW-1:0] m_flit;

  int            head_cyc[$];
  int            flit_cnt = 0;
  int            tail_cnt = 0;
  int            last_head_cyc = 0;
  int            last_tail_cyc = 0;
  int            last_acc_cyc  = 0;
  logic [FW-1:0] last_head_flit;

  task automatic check(input string tag, input logic [191:0] got, input logic [191:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [FW-1:0] exp_flit(input int k);
    logic [FDW-1:0] pl;
    pl = m_msg[MW-1-k*FDW -: FDW];
    return {1'b1, (k == 0), (k == NF-1), m_vc, m_dest, pl};
  endfunction

  function automatic logic [MW-1:0] rand_msg();
    logic [MW-1:0] d;
    d = '0;
    for (int i = 0; i < MW/32; i++) d = (d << 32) | MW'($urandom);
    return d;
  endfunction

  // One clock: check ready, advance the model over the coming edge, check flit_out.
  task automatic tick();
    logic [FW-1:0] nxt;
    bit send;
    int dec;
    #1;
    check("ready", 192'(ready_out), 192'(!m_busy && !rst));
    nxt = '0;
    send = 0;
    m_accept = 0;
    if (rst) begin
      m_busy = 0;
      m_k = 0;
      for (int v = 0; v < NVC; v++) m_cred[v] = BD;
    end else begin
      if (!m_busy) begin
        if (valid_in) begin
          m_msg = data_in; m_dest = dest_in; m_vc = vc_in;
          m_busy = 1; m_k = 0; m_accept = 1;
        end
      end else if (m_cred[m_vc] > 0) begin
        send = 1;
        nxt = exp_flit(m_k);
        m_k++;
        if (m_k == NF) m_busy = 0;
      end
      for (int v = 0; v < NVC; v++) begin
        dec = (send && v == int'(m_vc)) ? 1 : 0;
        m_cred[v] = m_cred[v] + int'(credit_in[v]) - dec;
        if (m_cred[v] > BD) m_cred[v] = BD;
      end
    end
    m_flit = nxt;
    @(posedge clk);
    cyc++;
    #1;
    check("flit", 192'(flit_out), 192'(m_flit));
    if (m_accept) last_acc_cyc = cyc;
    if (flit_out[FW-1]) flit_cnt++;
    if (flit_out[FW-1] && flit_out[FW-2]) begin
      head_cyc.push_back(cyc);
      last_head_cyc = cyc;
      last_head_flit = flit_out;
    end
    if (flit_out[FW-1] && flit_out[FW-3]) begin
      tail_cnt++;
      last_tail_cyc = cyc;
    end
  endtask

  task automatic send_msg(input logic [MW-1:0] d, input logic [NA-1:0] dst, input logic [VA-1:0] v);
    int b;
    b = 0;
    data_in = d; dest_in = dst; vc_in = v; valid_in = 1'b1;
    do begin tick(); b++; end while (!m_accept && b < 50);
    if (!m_accept) check("accept_timeout", 192'(1), 192'(0));
    valid_in = 1'b0;
  endtask

  task automatic drain();
    int b;
    b = 0;
    while (m_busy && b < 100) begin tick(); b++; end
    if (m_busy) check("drain_timeout", 192'(1), 192'(0));
  endtask

  initial begin
    int f0, t0, sz, p_cyc;
    logic [MW-1:0] basic;
    rst = 1'b1; data_in = '0; dest_in = '0; vc_in = '0; valid_in = 1'b0; credit_in = '0;
    d1_data = '0; d1_dest = '0; d1_vc = '0; d1_valid = 1'b0; d1_credit = '0;
    m_busy = 0; m_k = 0; m_flit = '0;
    for (int v = 0; v < NVC; v++) m_cred[v] = BD;
    @(posedge clk); #1;
    repeat (3) tick();
    rst = 1'b0;
    tick();

    // basic packet
    basic = {{16{8'hAA}}, {16{8'hBB}}, {16{8'hCC}}, {16{8'hDD}}};
    f0 = flit_cnt;
    send_msg(basic, 4'd5, 2'd2);
    drain();
    tick();
    check("basic_flits", 192'(flit_cnt - f0), 192'(NF));
    check("basic_head_lat", 192'(head_cyc[$] ), 192'(last_acc_cyc + 1));
    check("basic_tail_lat", 192'(last_tail_cyc), 192'(last_acc_cyc + NF));
    check("basic_tail_payload", 192'(flit_out), 192'(0));

    // credit stall on VC1
    send_msg(rand_msg(), 4'd1, 2'd1); drain();
    send_msg(rand_msg(), 4'd2, 2'd1); drain();
    send_msg(rand_msg(), 4'd3, 2'd1);
    f0 = flit_cnt;
    repeat (5) tick();
    check("stall_quiet", 192'(flit_cnt - f0), 192'(0));
    credit_in = 4'b0010; tick(); p_cyc = cyc; credit_in = '0;
    tick();
    check("stall_resume", 192'(last_head_cyc), 192'(p_cyc + 1));
    repeat (NF - 1) begin
      credit_in = 4'b0010; tick(); credit_in = '0; tick();
    end
    drain();
    check("stall_flits", 192'(flit_cnt - f0), 192'(NF));

    // simultaneous credit and send on VC0, then two packets with no credit
    credit_in = 4'b0001;
    send_msg(rand_msg(), 4'd6, 2'd0);
    drain();
    credit_in = '0;
    send_msg(rand_msg(), 4'd6, 2'd0); drain();
    check("simul_tail_lat1", 192'(last_tail_cyc), 192'(last_acc_cyc + NF));
    send_msg(rand_msg(), 4'd6, 2'd0); drain();
    check("simul_tail_lat2", 192'(last_tail_cyc), 192'(last_acc_cyc + NF));

    // refill every VC
    credit_in = '1;
    repeat (BD + 1) tick();
    credit_in = '0;

    // back-to-back with valid held
    sz = head_cyc.size();
    data_in = rand_msg(); dest_in = 4'd3; vc_in = 2'd0; valid_in = 1'b1;
    t0 = 0;
    do begin tick(); t0++; end while (!m_accept && t0 < 20);
    data_in = rand_msg(); dest_in = 4'd7; vc_in = 2'd3;
    t0 = 0;
    do begin tick(); t0++; end while (!m_accept && t0 < 20);
    valid_in = 1'b0;
    drain();
    if (head_cyc.size() >= sz + 2)
      check("b2b_gap", 192'(head_cyc[sz+1] - head_cyc[sz]), 192'(NF + 1));
    else
      check("b2b_heads", 192'(head_cyc.size() - sz), 192'(2));
    check("b2b_vc", 192'(last_head_flit[VA+NA+FDW-1 -: VA]), 192'(3));
    check("b2b_dest", 192'(last_head_flit[NA+FDW-1 -: NA]), 192'(7));

    // reset after flit 1
    send_msg(rand_msg(), 4'd4, 2'd2);
    tick(); tick();
    t0 = tail_cnt;
    rst = 1'b1; tick(); tick(); rst = 1'b0;
    repeat (8) tick();
    check("rst_no_tail", 192'(tail_cnt), 192'(t0));
    send_msg(rand_msg(), 4'd4, 2'd2); drain();
    send_msg(rand_msg(), 4'd4, 2'd2); drain();
    check("rst_cred_full", 192'(last_tail_cyc), 192'(last_acc_cyc + NF));

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      if (!valid_in && ($urandom_range(2) == 0)) begin
        data_in = rand_msg(); dest_in = NA'($urandom); vc_in = VA'($urandom); valid_in = 1'b1;
      end
      for (int v = 0; v < NVC; v++) credit_in[v] = ($urandom_range(3) == 0);
      tick();
      if (m_accept) valid_in = 1'b0;
    end
    valid_in = 1'b0;
    credit_in = '1;
    drain();
    credit_in = '0;
    tick();

    // single-flit build
    d1_data = {4{32'h1234_5678}}; d1_dest = 4'd9; d1_vc = 2'd1; d1_valid = 1'b1;
    tick();
    d1_valid = 1'b0;
    check("nf1_busy_ready", 192'(d1_ready), 192'(0));
    check("nf1_first_zero", 192'(d1_flit), 192'(0));
    tick();
    check("nf1_flit", 192'(d1_flit), 192'({1'b1, 1'b1, 1'b1, 2'd1, 4'd9, {4{32'h1234_5678}}}));
    check("nf1_ready_back", 192'(d1_ready), 192'(1));
    tick();
    check("nf1_after_zero", 192'(d1_flit), 192'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
